// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// and buffers returned instructions in a small in-order queue feeding if_id.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    // One extra bit so a redirect during an earlier discard cannot overflow.
    localparam int DW = CW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   ALIGN_M  = 32'hFFFF_FFFC;

    logic [31:0]      pc_r;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] filled_r;
    logic [31:0]      addr_r [DEPTH];
    logic [31:0]      inst_r [DEPTH];
    logic [AW-1:0]    head_r;
    logic [AW-1:0]    tail_r;
    logic [AW-1:0]    fill_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    pend_r;
    logic [DW-1:0]    discard_r;

    logic head_ready_s;
    logic pop_s;
    logic alloc_s;
    logic fill_s;
    logic drop_s;

    // Request, consume, fill decisions and the combinational head view.
    always_comb begin
        head_ready_s = valid_r[head_r] && filled_r[head_r];
        pop_s        = 1'b0;
        alloc_s      = 1'b0;
        fill_s       = 1'b0;
        drop_s       = 1'b0;
        imem_req_o   = 1'b0;
        imem_addr_o  = pc_r & ALIGN_M;
        inst_valid_o = 1'b0;
        inst_o       = NOP_INST;
        inst_addr_o  = 32'h0000_0000;
        if (rst) begin
            imem_req_o   = 1'b0;
            inst_valid_o = 1'b0;
        end else begin
            if (head_ready_s) begin
                inst_valid_o = 1'b1;
                inst_o       = inst_r[head_r];
                inst_addr_o  = addr_r[head_r];
            end else begin
                inst_valid_o = 1'b0;
            end
            pop_s      = head_ready_s && !hold_i && !jump_en_i;
            // Net occupancy: a pop this cycle frees room for a same-cycle grant.
            imem_req_o = !jump_en_i && ((count_r < DEPTH_C) || pop_s);
            alloc_s    = imem_req_o && imem_gnt_i;
            fill_s     = imem_rvalid_i && (discard_r == {DW{1'b0}}) &&
                         (pend_r != {CW{1'b0}}) && !jump_en_i;
            drop_s     = imem_rvalid_i && (discard_r != {DW{1'b0}});
        end
    end

    // PC, queue state and discard bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC & ALIGN_M;
            valid_r   <= {DEPTH{1'b0}};
            filled_r  <= {DEPTH{1'b0}};
            head_r    <= {AW{1'b0}};
            tail_r    <= {AW{1'b0}};
            fill_r    <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            pend_r    <= {CW{1'b0}};
            discard_r <= {DW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= 32'h0000_0000;
                inst_r[i] <= 32'h0000_0000;
            end
        end else if (jump_en_i) begin
            pc_r      <= jump_addr_i & ALIGN_M;
            valid_r   <= {DEPTH{1'b0}};
            filled_r  <= {DEPTH{1'b0}};
            head_r    <= {AW{1'b0}};
            tail_r    <= {AW{1'b0}};
            fill_r    <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            pend_r    <= {CW{1'b0}};
            // Every response still owed (older discards plus unfilled grants),
            // less the one arriving right now.
            discard_r <= discard_r + DW'(pend_r) - DW'(imem_rvalid_i);
        end else begin
            if (pop_s) begin
                valid_r[head_r]  <= 1'b0;
                filled_r[head_r] <= 1'b0;
                head_r           <= head_r + AW'(1);
            end
            // Written after the pop so a full-and-pop reuse of the slot keeps it valid.
            if (alloc_s) begin
                valid_r[tail_r]  <= 1'b1;
                filled_r[tail_r] <= 1'b0;
                addr_r[tail_r]   <= pc_r;
                tail_r           <= tail_r + AW'(1);
                pc_r             <= pc_r + 32'd4;
            end
            if (fill_s) begin
                filled_r[fill_r] <= 1'b1;
                inst_r[fill_r]   <= imem_rdata_i;
                fill_r           <= fill_r + AW'(1);
            end
            if (drop_s) begin
                discard_r <= discard_r - DW'(1);
            end
            count_r <= count_r + CW'(alloc_s) - CW'(pop_s);
            pend_r  <= pend_r + CW'(alloc_s) - CW'(fill_s);
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized checks of if_fetch against a simple in-order
// instruction memory model with configurable grant-to-rvalid latency.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        hold_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int errors = 0;
    int checks = 0;

    if_fetch #(.RESET_PC(RPC), .DEPTH(2), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_i(hold_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    function automatic logic [97:0] vec(input logic r, input logic [31:0] ia,
                                        input logic v, input logic [31:0] oa,
                                        input logic [31:0] i);
        return {r, ia, v, oa, i};
    endfunction

    // Memory model: in-order responses, each due a latency after its grant.
    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t q[$];
    int   cyc = 0;
    int   lat = 1;
    bit   rnd_lat = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q.delete();
        end else begin
            if (imem_rvalid_i) q.delete(0);
            if (imem_req_o && imem_gnt_i)
                q.push_back('{addr: imem_addr_o,
                              due: cyc + (rnd_lat ? int'($urandom_range(1, 3)) : lat)});
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
    end

    // Per-cycle stimulus and expectation tables used by the directed tests.
    logic [97:0] ev [12];
    logic        rv [12];
    logic        hv [12];
    logic        gv [12];
    logic        jv [12];
    logic [31:0] ja;
    logic [97:0] obs;

    task automatic clr_tab();
        for (int i = 0; i < 12; i++) begin
            rv[i] = 1'b0; hv[i] = 1'b0; gv[i] = 1'b1; jv[i] = 1'b0;
            ev[i] = 98'h0;
        end
        ja = 32'h0;
    endtask

    task automatic apply_reset(input int l);
        @(negedge clk);
        rst = 1'b1; jump_en_i = 1'b0; hold_i = 1'b0; imem_gnt_i = 1'b0;
        lat = l;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_cycle: got req=%b v=%b inst=%h oa=%h, expected req=0 v=0 inst=%h oa=0",
                     imem_req_o, inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        apply_reset(1);
        #1;
        obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
        checks++;
        if (obs !== vec(1'b0, RPC, 1'b0, 32'h0, NOP)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, vec(1'b0, RPC, 1'b0, 32'h0, NOP));
        end
    endtask

    task automatic test_stream();
        clr_tab();
        ev[0] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[2] = vec(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_C0DE);
        ev[3] = vec(1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 32'h0004_C0DE);
        ev[4] = vec(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 32'h0008_C0DE);
        ev[5] = vec(1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C, 32'h000C_C0DE);
        apply_reset(1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL stream cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_hold();
        clr_tab();
        for (int i = 0; i < 6; i++) hv[i] = 1'b1;
        ev[0] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        for (int i = 2; i < 6; i++) ev[i] = vec(1'b0, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_C0DE);
        ev[6] = vec(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_C0DE);
        ev[7] = vec(1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 32'h0004_C0DE);
        ev[8] = vec(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 32'h0008_C0DE);
        ev[9] = vec(1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C, 32'h000C_C0DE);
        apply_reset(1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL hold cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_redirect();
        clr_tab();
        jv[2] = 1'b1; ja = 32'h8000_0100;
        ev[0] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[2] = vec(1'b0, 32'h8000_0008, 1'b0, 32'h0, NOP);
        ev[3] = vec(1'b1, 32'h8000_0100, 1'b0, 32'h0, NOP);
        ev[4] = vec(1'b1, 32'h8000_0104, 1'b0, 32'h0, NOP);
        ev[5] = vec(1'b0, 32'h8000_0108, 1'b0, 32'h0, NOP);
        ev[6] = vec(1'b0, 32'h8000_0108, 1'b0, 32'h0, NOP);
        ev[7] = vec(1'b1, 32'h8000_0108, 1'b1, 32'h8000_0100, 32'h0100_C0DE);
        ev[8] = vec(1'b1, 32'h8000_010C, 1'b1, 32'h8000_0104, 32'h0104_C0DE);
        apply_reset(3);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL redirect cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_jump_rvalid();
        clr_tab();
        gv[1] = 1'b0; gv[2] = 1'b0; jv[2] = 1'b1; ja = 32'h8000_0100;
        ev[0] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[2] = vec(1'b0, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[3] = vec(1'b1, 32'h8000_0100, 1'b0, 32'h0, NOP);
        ev[4] = vec(1'b1, 32'h8000_0104, 1'b0, 32'h0, NOP);
        ev[5] = vec(1'b0, 32'h8000_0108, 1'b0, 32'h0, NOP);
        ev[6] = vec(1'b1, 32'h8000_0108, 1'b1, 32'h8000_0100, 32'h0100_C0DE);
        ev[7] = vec(1'b1, 32'h8000_010C, 1'b1, 32'h8000_0104, 32'h0104_C0DE);
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL jump_rvalid cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_wrap();
        clr_tab();
        jv[0] = 1'b1; ja = 32'hFFFF_FFF8;
        ev[0] = vec(1'b0, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, NOP);
        ev[2] = vec(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
        ev[3] = vec(1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 32'hFFF8_C0DE);
        ev[4] = vec(1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'hFFFC_C0DE);
        ev[5] = vec(1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_C0DE);
        apply_reset(1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL wrap cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clr_tab();
        rv[4] = 1'b1;
        ev[0] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[1] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[2] = vec(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_C0DE);
        ev[3] = vec(1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 32'h0004_C0DE);
        ev[4] = vec(1'b0, 32'h8000_0010, 1'b0, 32'h0, NOP);
        ev[5] = vec(1'b1, 32'h8000_0000, 1'b0, 32'h0, NOP);
        ev[6] = vec(1'b1, 32'h8000_0004, 1'b0, 32'h0, NOP);
        ev[7] = vec(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_C0DE);
        apply_reset(1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            rst = rv[i]; hold_i = hv[i]; imem_gnt_i = gv[i]; jump_en_i = jv[i]; jump_addr_i = ja;
            #1;
            obs = {imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_a;
        logic [31:0] tgt;
        int          occ;
        int          consumed;
        bit          took;
        exp_a = RPC; occ = 0; consumed = 0;
        apply_reset(1);
        rnd_lat = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) @(negedge clk);
            rst         = 1'b0;
            imem_gnt_i  = ($urandom_range(0, 3) != 0);
            hold_i      = ($urandom_range(0, 3) == 0);
            jump_en_i   = ($urandom_range(0, 39) == 0);
            tgt         = 32'h8000_1000 + 32'($urandom_range(0, 63)) * 32'd4;
            jump_addr_i = tgt;
            #1;
            took = inst_valid_o && !hold_i && !jump_en_i;
            if (took) begin
                checks++;
                if (inst_addr_o !== exp_a || inst_o !== mem_word(exp_a)) begin
                    errors++;
                    $display("FAIL random_seq cycle %0d: got addr=%h inst=%h expected addr=%h inst=%h",
                             c, inst_addr_o, inst_o, exp_a, mem_word(exp_a));
                end
                exp_a = exp_a + 32'd4;
                consumed++;
            end
            if (!inst_valid_o) begin
                checks++;
                if (inst_o !== NOP || inst_addr_o !== 32'h0) begin
                    errors++;
                    $display("FAIL random_idle cycle %0d: got inst=%h addr=%h expected inst=%h addr=0",
                             c, inst_o, inst_addr_o, NOP);
                end
            end
            if (jump_en_i) begin
                exp_a = tgt;
                occ   = 0;
            end else begin
                occ = occ + ((imem_req_o && imem_gnt_i) ? 1 : 0) - (took ? 1 : 0);
            end
            checks++;
            if (occ > 2 || occ < 0) begin
                errors++;
                $display("FAIL random_occupancy cycle %0d: got %0d expected 0..2", c, occ);
            end
        end
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL random_progress: got %0d instructions expected at least 200", consumed);
        end
        rnd_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_jump_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
